// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with load-use stall, flush bubbling, hold and bubble counters
module id_ex_pipe_reg #(
    parameter int         XLEN     = 32,
    parameter int         CNT_W    = 16,
    parameter logic [1:0] LOAD_SRC = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             br_taken_ex,
    input  logic             valid_id,
    input  logic [XLEN-1:0]  pc_id,
    input  logic [XLEN-1:0]  rs1_data_id,
    input  logic [XLEN-1:0]  rs2_data_id,
    input  logic [XLEN-1:0]  imm_id,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_id,
    input  logic [3:0]       ALUOp_id,
    input  logic [4:0]       BrOp_id,
    input  logic             AluASrc_id,
    input  logic             AluBSrc_id,
    input  logic [2:0]       DMCtrl_id,
    input  logic [1:0]       RUDataWrSrc_id,
    input  logic             RuWr_id,
    input  logic             DMWr_id,
    output logic             valid_ex,
    output logic [XLEN-1:0]  pc_ex,
    output logic [XLEN-1:0]  rs1_data_ex,
    output logic [XLEN-1:0]  rs2_data_ex,
    output logic [XLEN-1:0]  imm_ex,
    output logic [4:0]       rs1_ex,
    output logic [4:0]       rs2_ex,
    output logic [4:0]       rd_ex,
    output logic [3:0]       ALUOp_ex,
    output logic [4:0]       BrOp_ex,
    output logic             AluASrc_ex,
    output logic             AluBSrc_ex,
    output logic [2:0]       DMCtrl_ex,
    output logic [1:0]       RUDataWrSrc_ex,
    output logic             RuWr_ex,
    output logic             DMWr_ex,
    output logic             stall_id,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic [4:0]      br_op;
        logic            alu_a_src;
        logic            alu_b_src;
        logic [2:0]      dm_ctrl;
        logic [1:0]      wr_src;
        logic            ru_wr;
        logic            dm_wr;
    } stage_t;

    stage_t     id_s, ex_d, ex_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q, flush_cnt_d, flush_cnt_q;
    logic       load_use;

    assign id_s = '{valid: valid_id, pc: pc_id, rs1_data: rs1_data_id, rs2_data: rs2_data_id,
                    imm: imm_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id, alu_op: ALUOp_id,
                    br_op: BrOp_id, alu_a_src: AluASrc_id, alu_b_src: AluBSrc_id,
                    dm_ctrl: DMCtrl_id, wr_src: RUDataWrSrc_id, ru_wr: RuWr_id, dm_wr: DMWr_id};

    assign load_use = ex_q.valid & ex_q.ru_wr & (ex_q.wr_src == LOAD_SRC) & (ex_q.rd != 5'd0)
                    & valid_id & ((ex_q.rd == rs1_id) | (ex_q.rd == rs2_id));
    assign stall_id = load_use & ~br_taken_ex;

    always_comb begin
        ex_d         = hold ? ex_q : (br_taken_ex | load_use) ? '0 : id_s;
        flush_cnt_d  = (!hold && br_taken_ex && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        bubble_cnt_d = (!hold && stall_id && !(&bubble_cnt_q)) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign valid_ex       = ex_q.valid;
    assign pc_ex          = ex_q.pc;
    assign rs1_data_ex    = ex_q.rs1_data;
    assign rs2_data_ex    = ex_q.rs2_data;
    assign imm_ex         = ex_q.imm;
    assign rs1_ex         = ex_q.rs1;
    assign rs2_ex         = ex_q.rs2;
    assign rd_ex          = ex_q.rd;
    assign ALUOp_ex       = ex_q.alu_op;
    assign BrOp_ex        = ex_q.br_op;
    assign AluASrc_ex     = ex_q.alu_a_src;
    assign AluBSrc_ex     = ex_q.alu_b_src;
    assign DMCtrl_ex      = ex_q.dm_ctrl;
    assign RUDataWrSrc_ex = ex_q.wr_src;
    assign RuWr_ex        = ex_q.ru_wr;
    assign DMWr_ex        = ex_q.dm_wr;
    assign bubble_cnt     = bubble_cnt_q;
    assign flush_cnt      = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: scoreboard bench for id_ex_pipe_reg with 2-bit saturating counters
module tb_id_ex_pipe_reg;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic [4:0]  br_op;
        logic        asrc;
        logic        bsrc;
        logic [2:0]  dm_ctrl;
        logic [1:0]  wsrc;
        logic        ruwr;
        logic        dmwr;
    } st_t;

    typedef struct packed {
        st_t             ex;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk = 0, rst_n = 0, hold = 0, br_taken_ex = 0;
    st_t  id = '0, obs, m = '0;
    logic [CNT_W-1:0] m_bc = '0, m_fc = '0;
    logic valid_ex, RuWr_ex, DMWr_ex, AluASrc_ex, AluBSrc_ex, stall_id;
    logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0] rs1_ex, rs2_ex, rd_ex, BrOp_ex;
    logic [3:0] ALUOp_ex;
    logic [2:0] DMCtrl_ex;
    logic [1:0] RUDataWrSrc_ex;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(CNT_W), .LOAD_SRC(2'b01)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .br_taken_ex(br_taken_ex),
        .valid_id(id.valid), .pc_id(id.pc), .rs1_data_id(id.rs1_data), .rs2_data_id(id.rs2_data),
        .imm_id(id.imm), .rs1_id(id.rs1), .rs2_id(id.rs2), .rd_id(id.rd), .ALUOp_id(id.alu_op),
        .BrOp_id(id.br_op), .AluASrc_id(id.asrc), .AluBSrc_id(id.bsrc), .DMCtrl_id(id.dm_ctrl),
        .RUDataWrSrc_id(id.wsrc), .RuWr_id(id.ruwr), .DMWr_id(id.dmwr),
        .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
        .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .ALUOp_ex(ALUOp_ex),
        .BrOp_ex(BrOp_ex), .AluASrc_ex(AluASrc_ex), .AluBSrc_ex(AluBSrc_ex), .DMCtrl_ex(DMCtrl_ex),
        .RUDataWrSrc_ex(RUDataWrSrc_ex), .RuWr_ex(RuWr_ex), .DMWr_ex(DMWr_ex),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    assign obs = '{valid: valid_ex, pc: pc_ex, rs1_data: rs1_data_ex, rs2_data: rs2_data_ex,
                   imm: imm_ex, rs1: rs1_ex, rs2: rs2_ex, rd: rd_ex, alu_op: ALUOp_ex,
                   br_op: BrOp_ex, asrc: AluASrc_ex, bsrc: AluBSrc_ex, dm_ctrl: DMCtrl_ex,
                   wsrc: RUDataWrSrc_ex, ruwr: RuWr_ex, dmwr: DMWr_ex};

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic st_t mk(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic ruwr, input logic [1:0] wsrc);
        st_t s;
        s = '{valid: v, pc: $urandom, rs1_data: $urandom, rs2_data: $urandom, imm: $urandom,
              rs1: rs1, rs2: rs2, rd: rd, alu_op: 4'($urandom), br_op: 5'($urandom),
              asrc: 1'($urandom), bsrc: 1'($urandom), dm_ctrl: 3'($urandom), wsrc: wsrc,
              ruwr: ruwr, dmwr: 1'($urandom)};
        return s;
    endfunction

    // Drive one ID slot between edges, check stall, then compare EX after the edge via the scoreboard.
    task automatic step(input st_t s, input logic br, input logic hd, input string tag);
        logic lu;
        exp_t e;
        id = s; br_taken_ex = br; hold = hd;
        lu = m.valid && m.ruwr && m.wsrc == 2'b01 && m.rd != 0 && s.valid && (m.rd == s.rs1 || m.rd == s.rs2);
        #1;
        chk({tag, ".stall"}, 192'(stall_id), 192'(lu && !br));
        if (!hd) begin
            if (br) begin
                m = '0;
                if (m_fc != '1) m_fc++;
            end else if (lu) begin
                m = '0;
                if (m_bc != '1) m_bc++;
            end else m = s;
        end
        sb.push_back('{ex: m, bc: m_bc, fc: m_fc});
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({tag, ".ex"}, 192'(obs), 192'(e.ex));
        chk({tag, ".cnt"}, 192'({bubble_cnt, flush_cnt}), 192'({e.bc, e.fc}));
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, ".ex"}, 192'(obs), 192'(0));
        chk({tag, ".cnt"}, 192'({bubble_cnt, flush_cnt}), 192'(0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        zero_chk("rst_init");
        rst_n = 1;
        step(mk(1, 3, 1, 2, 1, 2'b00), 0, 0, "add");
        chk("add.rd", 192'(rd_ex), 192'(3));
        step(mk(1, 5, 1, 0, 1, 2'b01), 0, 0, "lw5");
        step(mk(1, 9, 5, 2, 1, 2'b00), 0, 0, "dep_stall");
        step(mk(1, 9, 5, 2, 1, 2'b00), 0, 0, "dep_go");
        chk("bubble1", 192'(bubble_cnt), 192'(1));
        step(mk(1, 0, 1, 0, 1, 2'b01), 0, 0, "lw0");
        step(mk(1, 4, 0, 0, 1, 2'b00), 0, 0, "dep_x0");
        step(mk(1, 7, 1, 0, 1, 2'b01), 0, 0, "lw7");
        step(mk(1, 4, 5, 6, 1, 2'b00), 0, 0, "nodep7");
        step(mk(1, 7, 1, 0, 1, 2'b01), 0, 0, "lw7b");
        step(mk(0, 4, 7, 7, 1, 2'b00), 0, 0, "inv_id");
        step(mk(1, 5, 1, 0, 1, 2'b01), 0, 0, "lw5b");
        step(mk(1, 8, 5, 5, 1, 2'b00), 1, 0, "flush_lu");
        chk("flush1", 192'({bubble_cnt, flush_cnt}), 192'({2'd1, 2'd1}));
        step(mk(1, 6, 1, 2, 1, 2'b00), 0, 0, "pre_hold");
        for (int i = 0; i < 3; i++) step(mk(1, 5'(i + 10), 3, 4, 1, 2'b01), i[0], 1, "hold");
        for (int i = 0; i < 5; i++) step(mk(1, 2, 1, 1, 1, 2'b00), 1, 0, "flush_sat");
        chk("flush_sat", 192'(flush_cnt), 192'(3));
        for (int i = 0; i < 40; i++)
            step(mk(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3))),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, "rnd");
        hold = 0; br_taken_ex = 0;
        step(mk(1, 12, 1, 2, 1, 2'b00), 0, 0, "pre_rst");
        #2 rst_n = 0;
        #1 zero_chk("rst_mid");
        @(posedge clk); #1;
        zero_chk("rst_held");
        rst_n = 1; m = '0; m_bc = '0; m_fc = '0;
        step(mk(1, 13, 1, 2, 1, 2'b00), 0, 0, "post_rst");
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
